// File: rtl/dma_desc_sched.sv
// dma_desc_sched: walks enabled DMA descriptors and issues one engine command each.
// Optional busy-cycle counter: define DMA_SCHED_PERF_EN.
module dma_desc_sched #(
  parameter int NUM_DESC    = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int BYTES_WIDTH = 32,
  localparam int IW = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            go_i,
  input  logic                            abort_i,
  input  logic [NUM_DESC-1:0]             desc_en_i,
  input  logic [NUM_DESC*ADDR_WIDTH-1:0]  desc_src_i,
  input  logic [NUM_DESC*ADDR_WIDTH-1:0]  desc_dst_i,
  input  logic [NUM_DESC*BYTES_WIDTH-1:0] desc_bytes_i,
  input  logic [NUM_DESC-1:0]             desc_wr_mode_i,
  input  logic [NUM_DESC-1:0]             desc_rd_mode_i,
  output logic                            xfer_valid_o,
  input  logic                            xfer_ready_i,
  output logic [ADDR_WIDTH-1:0]           xfer_src_o,
  output logic [ADDR_WIDTH-1:0]           xfer_dst_o,
  output logic [BYTES_WIDTH-1:0]          xfer_bytes_o,
  output logic                            xfer_wr_mode_o,
  output logic                            xfer_rd_mode_o,
  output logic [IW-1:0]                   xfer_idx_o,
  output logic                            xfer_abort_o,
  input  logic                            xfer_done_i,
  input  logic                            xfer_error_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            error_o,
  output logic                            aborted_o,
  output logic [IW-1:0]                   err_idx_o,
  output logic [31:0]                     perf_cycles_o
);

  localparam int PW = $clog2(NUM_DESC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_ISSUE,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t state, state_n;

  logic                   go_q;
  logic                   abort_q;
  logic [NUM_DESC-1:0]    en_snap;
  logic [PW-1:0]          ptr;
  logic                   go_edge;
  logic                   abort_any;

  logic                   found;
  logic [IW-1:0]          pick_idx;
  logic [ADDR_WIDTH-1:0]  pick_src;
  logic [ADDR_WIDTH-1:0]  pick_dst;
  logic [BYTES_WIDTH-1:0] pick_bytes;
  logic                   pick_wr;
  logic                   pick_rd;

  logic start;
  logic capture;
  logic hs;
  logic set_err;
  logic set_abt;
  logic fin;

  assign go_edge   = go_i && !go_q;
  assign abort_any = abort_q || abort_i;

  // Lowest eligible slot at or above ptr; descending loop so lowest wins.
  always_comb begin
    found      = 1'b0;
    pick_idx   = '0;
    pick_src   = '0;
    pick_dst   = '0;
    pick_bytes = '0;
    pick_wr    = 1'b0;
    pick_rd    = 1'b0;
    for (int i = NUM_DESC - 1; i >= 0; i--) begin
      if (en_snap[i] &&
          desc_bytes_i[i*BYTES_WIDTH +: BYTES_WIDTH] != '0 &&
          PW'(i) >= ptr) begin
        found      = 1'b1;
        pick_idx   = IW'(i);
        pick_src   = desc_src_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        pick_dst   = desc_dst_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        pick_bytes = desc_bytes_i[i*BYTES_WIDTH +: BYTES_WIDTH];
        pick_wr    = desc_wr_mode_i[i];
        pick_rd    = desc_rd_mode_i[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    capture = 1'b0;
    hs      = 1'b0;
    set_err = 1'b0;
    set_abt = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (go_edge) begin
          start   = 1'b1;
          state_n = S_SCAN;
        end
      end
      S_SCAN: begin
        if (abort_i) begin
          set_abt = 1'b1;
          state_n = S_FINISH;
        end else if (found) begin
          capture = 1'b1;
          state_n = S_ISSUE;
        end else begin
          state_n = S_FINISH;
        end
      end
      S_ISSUE: begin
        if (abort_i) begin
          set_abt = 1'b1;
          state_n = S_FINISH;
        end else if (xfer_ready_i) begin
          hs      = 1'b1;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (xfer_done_i) begin
          set_err = xfer_error_i;
          set_abt = abort_any;
          if (xfer_error_i || abort_any ||
              ptr == PW'(NUM_DESC))
            state_n = S_FINISH;
          else
            state_n = S_SCAN;
        end
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Sticky flags rise together with entry into FINISH.
  assign fin = (state != S_FINISH) && (state_n == S_FINISH);

  always_ff @(posedge clk) begin
    if (rst) begin
      go_q           <= 1'b0;
      abort_q        <= 1'b0;
      en_snap        <= '0;
      ptr            <= '0;
      xfer_src_o     <= '0;
      xfer_dst_o     <= '0;
      xfer_bytes_o   <= '0;
      xfer_wr_mode_o <= 1'b0;
      xfer_rd_mode_o <= 1'b0;
      xfer_idx_o     <= '0;
      done_o         <= 1'b0;
      error_o        <= 1'b0;
      aborted_o      <= 1'b0;
      err_idx_o      <= '0;
    end else begin
      go_q <= go_i;
      if (start) begin
        done_o    <= 1'b0;
        error_o   <= 1'b0;
        aborted_o <= 1'b0;
        abort_q   <= 1'b0;
        en_snap   <= desc_en_i;
        ptr       <= '0;
      end
      if (capture) begin
        xfer_src_o     <= pick_src;
        xfer_dst_o     <= pick_dst;
        xfer_bytes_o   <= pick_bytes;
        xfer_wr_mode_o <= pick_wr;
        xfer_rd_mode_o <= pick_rd;
        xfer_idx_o     <= pick_idx;
      end
      if (hs)
        ptr <= PW'(xfer_idx_o) + PW'(1);
      if (state == S_WAIT && abort_i)
        abort_q <= 1'b1;
      if (fin) begin
        done_o  <= 1'b1;
        abort_q <= 1'b0;
      end
      if (set_err) begin
        error_o   <= 1'b1;
        err_idx_o <= xfer_idx_o;
      end
      if (set_abt)
        aborted_o <= 1'b1;
    end
  end

  // Handshake outputs drop with reset or abort without waiting for an edge.
  assign busy_o       = (state != S_IDLE);
  assign xfer_valid_o = (state == S_ISSUE) && !abort_i && !rst;
  assign xfer_abort_o = (state == S_WAIT) && abort_any && !rst;

`ifdef DMA_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst)
      perf_cycles_o <= '0;
    else if (start)
      perf_cycles_o <= '0;
    else if (busy_o && perf_cycles_o != 32'hFFFF_FFFF)
      perf_cycles_o <= perf_cycles_o + 32'd1;
  end
`else
  assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_dma_desc_sched.sv
// tb_dma_desc_sched: directed and randomized runs against a queue-based model
// of the descriptor walk and a small engine responder.
module tb_dma_desc_sched;

  localparam int ND = 2;
  localparam int AW = 32;
  localparam int BW = 32;
  localparam int IW = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             go_i;
  logic             abort_i;
  logic [ND-1:0]    desc_en_i;
  logic [ND*AW-1:0] desc_src_i;
  logic [ND*AW-1:0] desc_dst_i;
  logic [ND*BW-1:0] desc_bytes_i;
  logic [ND-1:0]    desc_wr_mode_i;
  logic [ND-1:0]    desc_rd_mode_i;
  logic             xfer_valid_o;
  logic             xfer_ready_i;
  logic [AW-1:0]    xfer_src_o;
  logic [AW-1:0]    xfer_dst_o;
  logic [BW-1:0]    xfer_bytes_o;
  logic             xfer_wr_mode_o;
  logic             xfer_rd_mode_o;
  logic [IW-1:0]    xfer_idx_o;
  logic             xfer_abort_o;
  logic             xfer_done_i;
  logic             xfer_error_i;
  logic             busy_o;
  logic             done_o;
  logic             error_o;
  logic             aborted_o;
  logic [IW-1:0]    err_idx_o;
  logic [31:0]      perf_cycles_o;

  int vectors = 0;
  int miscompares = 0;

  logic [ND-1:0] en_cfg;
  logic [AW-1:0] src_a   [ND];
  logic [AW-1:0] dst_a   [ND];
  logic [BW-1:0] bytes_a [ND];
  logic          wr_a    [ND];
  logic          rd_a    [ND];

  always #5 clk = ~clk;

  dma_desc_sched #(
    .NUM_DESC   (ND),
    .ADDR_WIDTH (AW),
    .BYTES_WIDTH(BW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .go_i          (go_i),
    .abort_i       (abort_i),
    .desc_en_i     (desc_en_i),
    .desc_src_i    (desc_src_i),
    .desc_dst_i    (desc_dst_i),
    .desc_bytes_i  (desc_bytes_i),
    .desc_wr_mode_i(desc_wr_mode_i),
    .desc_rd_mode_i(desc_rd_mode_i),
    .xfer_valid_o  (xfer_valid_o),
    .xfer_ready_i  (xfer_ready_i),
    .xfer_src_o    (xfer_src_o),
    .xfer_dst_o    (xfer_dst_o),
    .xfer_bytes_o  (xfer_bytes_o),
    .xfer_wr_mode_o(xfer_wr_mode_o),
    .xfer_rd_mode_o(xfer_rd_mode_o),
    .xfer_idx_o    (xfer_idx_o),
    .xfer_abort_o  (xfer_abort_o),
    .xfer_done_i   (xfer_done_i),
    .xfer_error_i  (xfer_error_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .error_o       (error_o),
    .aborted_o     (aborted_o),
    .err_idx_o     (err_idx_o),
    .perf_cycles_o (perf_cycles_o)
  );

  task automatic drive_desc();
    desc_en_i = en_cfg;
    for (int i = 0; i < ND; i++) begin
      desc_src_i[i*AW +: AW]   = src_a[i];
      desc_dst_i[i*AW +: AW]   = dst_a[i];
      desc_bytes_i[i*BW +: BW] = bytes_a[i];
      desc_wr_mode_i[i]        = wr_a[i];
      desc_rd_mode_i[i]        = rd_a[i];
    end
  endtask

  task automatic set_slot(input int i, input logic [AW-1:0] s,
                          input logic [AW-1:0] d, input logic [BW-1:0] b,
                          input logic w, input logic r);
    src_a[i]   = s;
    dst_a[i]   = d;
    bytes_a[i] = b;
    wr_a[i]    = w;
    rd_a[i]    = r;
  endtask

  // lat: 0 none, 1 first valid at go+2, 2 done at go+2 with no command
  task automatic run_case(input string name, input int rdy_dly,
                          input int done_dly, input int err_slot,
                          input int abort_slot, input int lat,
                          input bit scramble);
    int exp_q[$];
    int n_exp = 0;
    int cyc = 0;
    int busy_n = 0;
    int dcnt = 0;
    int rcnt = 0;
    int cur = 0;
    int issued = 0;
    int e = 0;
    int last = 0;
    int exp_perf = 0;
    bit outst = 0;
    bit vseen = 0;
    bit ab_sent = 0;
    bit ab_pend = 0;
    bit fin = 0;
    bit exp_err = 0;
    bit exp_abt = 0;
    logic [AW-1:0] h_src;
    logic [AW-1:0] h_dst;
    logic [BW-1:0] h_bytes;
    logic [IW-1:0] h_idx;
    logic          h_wr;
    logic          h_rd;

    for (int i = 0; i < ND; i++) begin
      if (en_cfg[i] && bytes_a[i] != '0) begin
        exp_q.push_back(i);
        last = i;
        if (i == err_slot) exp_err = 1;
        if (i == abort_slot) exp_abt = 1;
        if (exp_err || exp_abt) break;
      end
    end
    n_exp = exp_q.size();

    drive_desc();
    @(negedge clk);
    go_i = 1'b0; abort_i = 1'b0;
    xfer_ready_i = 1'b0; xfer_done_i = 1'b0; xfer_error_i = 1'b0;
    @(negedge clk);
    go_i = 1'b1;

    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      go_i = scramble ? 1'($urandom) : 1'b0;
      xfer_ready_i = 1'b0;
      xfer_done_i  = 1'b0;
      xfer_error_i = 1'b0;
      abort_i      = 1'b0;
      if (outst) begin
        if (cur == abort_slot && !ab_sent) begin
          abort_i = 1'b1; ab_sent = 1; ab_pend = 1;
        end
        if (dcnt == 0) begin
          xfer_done_i  = 1'b1;
          xfer_error_i = (cur == err_slot);
          outst = 0;
        end else begin
          dcnt--;
        end
      end
      #1;
      if (busy_o === 1'b1) busy_n++;
      if (cyc == 1) begin
        vectors++;
        if ({done_o, error_o, aborted_o} !== 3'b000) begin
          miscompares++;
          $display("FAIL %s flags_clear: got %b want 000", name,
                   {done_o, error_o, aborted_o});
        end
      end
      vectors++;
      if (xfer_abort_o !== ab_pend) begin
        miscompares++;
        $display("FAIL %s xfer_abort cyc%0d: got %b want %b", name, cyc,
                 xfer_abort_o, ab_pend);
      end
      if (xfer_done_i) ab_pend = 0;

      if (xfer_valid_o === 1'b1) begin
        if (!vseen) begin
          vseen = 1; rcnt = rdy_dly;
          h_src = xfer_src_o; h_dst = xfer_dst_o; h_bytes = xfer_bytes_o;
          h_idx = xfer_idx_o; h_wr = xfer_wr_mode_o; h_rd = xfer_rd_mode_o;
          if (lat == 1 && issued == 0) begin
            vectors++;
            if (cyc != 2) begin
              miscompares++;
              $display("FAIL %s valid_latency: got %0d want 2", name, cyc);
            end
          end
        end else begin
          vectors++;
          if ({xfer_src_o, xfer_dst_o, xfer_bytes_o, xfer_idx_o,
               xfer_wr_mode_o, xfer_rd_mode_o} !==
              {h_src, h_dst, h_bytes, h_idx, h_wr, h_rd}) begin
            miscompares++;
            $display("FAIL %s cmd_stable: got %h/%h want %h/%h", name,
                     xfer_src_o, xfer_bytes_o, h_src, h_bytes);
          end
        end
        if (rcnt == 0) begin
          xfer_ready_i = 1'b1;
          vseen = 0;
          issued++;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s extra_cmd: got idx %0d want none", name,
                     xfer_idx_o);
            cur = int'(xfer_idx_o);
          end else begin
            e = exp_q.pop_front();
            cur = e;
            if (xfer_idx_o !== IW'(e) || xfer_src_o !== src_a[e] ||
                xfer_dst_o !== dst_a[e] || xfer_bytes_o !== bytes_a[e] ||
                xfer_wr_mode_o !== wr_a[e] || xfer_rd_mode_o !== rd_a[e]) begin
              miscompares++;
              $display("FAIL %s cmd_fields: got %0d %h %h %h %b%b want %0d %h %h %h %b%b",
                       name, xfer_idx_o, xfer_src_o, xfer_dst_o, xfer_bytes_o,
                       xfer_wr_mode_o, xfer_rd_mode_o, e, src_a[e], dst_a[e],
                       bytes_a[e], wr_a[e], rd_a[e]);
            end
          end
          outst = 1; dcnt = done_dly;
          if (scramble) begin
            desc_en_i = ND'($urandom);
            for (int j = 0; j < ND; j++) begin
              dst_a[j] = $urandom;
              desc_dst_i[j*AW +: AW] = dst_a[j];
            end
          end
        end else begin
          rcnt--;
        end
      end

      if (done_o === 1'b1) begin
        fin = 1;
        if (lat == 2) begin
          vectors++;
          if (cyc != 2) begin
            miscompares++;
            $display("FAIL %s done_latency: got %0d want 2", name, cyc);
          end
        end
      end
    end

    vectors++;
    if (!fin) begin
      miscompares++;
      $display("FAIL %s timeout: got no done want done_o", name);
    end
    vectors++;
    if (issued != n_exp) begin
      miscompares++;
      $display("FAIL %s cmd_count: got %0d want %0d", name, issued, n_exp);
    end
    vectors++;
    if ({error_o, aborted_o, busy_o} !== {exp_err, exp_abt, 1'b1}) begin
      miscompares++;
      $display("FAIL %s end_flags: got %b%b%b want %b%b1", name,
               error_o, aborted_o, busy_o, exp_err, exp_abt);
    end
    if (exp_err) begin
      vectors++;
      if (err_idx_o !== IW'(last)) begin
        miscompares++;
        $display("FAIL %s err_idx: got %0d want %0d", name, err_idx_o, last);
      end
    end

    @(negedge clk);
    go_i = 1'b0; abort_i = 1'b0;
    xfer_ready_i = 1'b0; xfer_done_i = 1'b0; xfer_error_i = 1'b0;
    #1;
    vectors++;
    if ({busy_o, done_o} !== 2'b01) begin
      miscompares++;
      $display("FAIL %s idle_after: got busy=%b done=%b want 0 1", name,
               busy_o, done_o);
    end
`ifdef DMA_SCHED_PERF_EN
    exp_perf = busy_n;
`else
    exp_perf = 0;
`endif
    vectors++;
    if (perf_cycles_o !== 32'(exp_perf)) begin
      miscompares++;
      $display("FAIL %s perf: got %0d want %0d", name, perf_cycles_o, exp_perf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; go_i = 1'b0; abort_i = 1'b0;
    xfer_ready_i = 1'b0; xfer_done_i = 1'b0; xfer_error_i = 1'b0;
    en_cfg = '0;
    for (int i = 0; i < ND; i++) set_slot(i, '0, '0, '0, 1'b0, 1'b0);
    drive_desc();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({xfer_valid_o, xfer_abort_o, busy_o, done_o, error_o, aborted_o} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 000000", {xfer_valid_o,
               xfer_abort_o, busy_o, done_o, error_o, aborted_o});
    end
    vectors++;
    if ({xfer_src_o, xfer_dst_o, xfer_bytes_o, xfer_idx_o, err_idx_o,
         xfer_wr_mode_o, xfer_rd_mode_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_cmd: got %h %h %h want 0", xfer_src_o, xfer_dst_o,
               xfer_bytes_o);
    end
    vectors++;
    if (perf_cycles_o !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_perf: got %0d want 0", perf_cycles_o);
    end
  endtask

  task automatic test_two_slots();
    en_cfg = 2'b11;
    set_slot(0, 32'h1000, 32'h8000, 32'd64, 1'b0, 1'b1);
    set_slot(1, 32'h2000, 32'h9000, 32'd128, 1'b1, 1'b0);
    run_case("two_slots", 0, 9, 99, 99, 1, 0);
  endtask

  task automatic test_skip();
    en_cfg = 2'b10;
    run_case("en_10", 0, 4, 99, 99, 1, 0);
    en_cfg = 2'b11;
    bytes_a[0] = '0;
    run_case("zero_bytes", 0, 4, 99, 99, 0, 0);
    en_cfg = 2'b00;
    bytes_a[0] = 32'd64;
    run_case("empty", 0, 4, 99, 99, 2, 0);
  endtask

  task automatic test_ready_stall();
    en_cfg = 2'b11;
    run_case("ready_stall", 5, 3, 99, 99, 1, 0);
  endtask

  task automatic test_error();
    en_cfg = 2'b11;
    run_case("error_slot0", 0, 6, 0, 99, 0, 0);
  endtask

  task automatic test_abort_restart();
    en_cfg = 2'b11;
    run_case("abort_wait", 0, 10, 99, 0, 0, 0);
    run_case("restart", 1, 3, 99, 99, 1, 0);
  endtask

  task automatic test_perf();
    en_cfg = 2'b01;
    run_case("perf_1slot", 0, 7, 99, 99, 1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      en_cfg = ND'($urandom);
      for (int i = 0; i < ND; i++)
        set_slot(i, $urandom, $urandom,
                 ($urandom_range(0, 3) == 0) ? '0 : BW'($urandom),
                 1'($urandom), 1'($urandom));
      run_case($sformatf("rand%0d", n), $urandom_range(0, 4),
               $urandom_range(1, 12), $urandom_range(0, 3),
               $urandom_range(0, 3), 0, 1);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    en_cfg = 2'b11;
    set_slot(0, 32'h1000, 32'h8000, 32'd64, 1'b0, 1'b0);
    set_slot(1, 32'h2000, 32'h9000, 32'd128, 1'b0, 1'b0);
    drive_desc();
    @(negedge clk); go_i = 1'b0;
    @(negedge clk); go_i = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      go_i = 1'b0;
      if (xfer_valid_o === 1'b1) seen = 1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL reset_mid_valid: got no valid want valid");
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({xfer_valid_o, xfer_abort_o, busy_o, done_o} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got %b want 0000",
               {xfer_valid_o, xfer_abort_o, busy_o, done_o});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_two_slots();
    test_skip();
    test_ready_stall();
    test_error();
    test_abort_restart();
    test_perf();
    test_random();
    test_reset_mid();
    test_two_slots();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
